pipe_ctl: RTL and testbench
===========================

PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 SHALL have port clk, input, 1: 100 MHz system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset; 0 = reset asserted.
REQ-003 SHALL have port tick, input, 1: one-clk strobe marking each pipeline-clock edge, from the clock divider.
REQ-004 SHALL have port pause, input, 1: level from the pause switch; 1 = hold the pipeline.
REQ-005 SHALL have port step, input, 1: one-clk press strobe from the step debouncer (btn_down).
REQ-006 SHALL have port clr, input, 1: synchronous clear of both counters.
REQ-007 SHALL have ports id_rs and id_rt, input, 4 each: source register fields of the instruction in IF/ID.
REQ-008 SHALL have port id_uses_rt, input, 1: 1 = the instruction in ID reads rt.
REQ-009 SHALL have ports ex_memread, input, 1, and ex_wa, input, 4: load flag and write address in ID/EX.
REQ-010 SHALL have ports wb_regwrite, input, 1, and wb_wa, input, 4: writeback enable and address.
REQ-011 SHALL have port pipe_en, output, 1: advance EX/MEM/WB and the ID/EX register this tick.
REQ-012 SHALL have port if_en, output, 1: load PC and IF/ID this tick.
REQ-013 SHALL have port id_flush, output, 1: load a bubble (all control fields 0) into ID/EX this tick.
REQ-014 SHALL have port state, output, 2: 00 HALT, 01 RUN, 10 STEP.
REQ-015 SHALL have ports cycle_cnt and stall_cnt, output, 16 each: advance and stall counters.

Function
REQ-016 SHALL be a registered 3-state FSM; 11 is unreachable and SHALL recover to HALT on the next clk.
REQ-017 HALT: pause=0 -> RUN; otherwise step=1 -> STEP; otherwise remain in HALT.
REQ-018 RUN: on a tick with pause=1 -> HALT after that tick's advance; step is ignored.
REQ-019 STEP: the first tick performs exactly one advance, then -> HALT; further step strobes are ignored, with no queuing.
REQ-020 Simultaneous step and tick while in HALT: the FSM SHALL enter STEP, and the advance SHALL occur on the next tick, not the current one.
REQ-021 pipe_en SHALL equal tick AND (state = RUN OR state = STEP), combinationally, with zero latency from tick.
REQ-022 load_use SHALL be ex_memread AND (ex_wa = id_rs OR (id_uses_rt AND ex_wa = id_rt)).
REQ-023 wb_conflict SHALL be wb_regwrite AND (wb_wa = id_rs OR (id_uses_rt AND wb_wa = id_rt)); this enforces no same-cycle read and write in the register file.
REQ-024 stall SHALL be load_use OR wb_conflict; register 0 SHALL NOT be treated as special.
REQ-025 if_en SHALL be pipe_en AND NOT stall; id_flush SHALL be pipe_en AND stall.
REQ-026 A STEP advance that coincides with a stall SHALL consume the step: a bubble is inserted and PC is held.
REQ-027 cycle_cnt SHALL increment on every pipe_en and wrap from FFFF to 0000.
REQ-028 stall_cnt SHALL increment on every id_flush and saturate at FFFF.
REQ-029 clr=1 SHALL zero both counters on that clk, taking priority over any increment in the same cycle.

Reset
REQ-030 rst=0 SHALL immediately force state = HALT, cycle_cnt = 0 and stall_cnt = 0, independent of clk.
REQ-031 While rst=0, pipe_en, if_en and id_flush SHALL be 0, including mid-STEP and mid-RUN.
REQ-032 After rst deasserts, the first clk edge SHALL evaluate the HALT transitions.

Configuration
REQ-033 With PIPE_CTL_HAZARD_EN defined, REQ-022 through REQ-026 and REQ-028 SHALL apply.
REQ-034 Without PIPE_CTL_HAZARD_EN, stall SHALL be constant 0: if_en = pipe_en, id_flush = 0, stall_cnt held at 0, and the hazard inputs unused.

Verification
REQ-035 Reset, pause=0, ticks every 4 clk -> state 01 after 1 clk; pipe_en pulses with each tick; cycle_cnt = 10 after 10 ticks.
REQ-036 pause=1 in RUN, then one step strobe between ticks -> exactly one pipe_en on the next tick, state 10 -> 00, cycle_cnt +1; a second strobe during STEP adds nothing.
REQ-037 HAZARD_EN, ex_memread=1, ex_wa=5, id_rs=5, tick -> if_en=0, id_flush=1, stall_cnt=1; with id_rs=6, id_rt=5, id_uses_rt=0 -> no stall.
REQ-038 HAZARD_EN, wb_regwrite=1, wb_wa=3, id_rt=3, id_uses_rt=1 -> id_flush=1 on that tick.
REQ-039 Preload stall_cnt to FFFF via forced stalls, one more stall -> stall_cnt stays FFFF; clr with a coincident stall -> 0000.
REQ-040 rst pulled low between clk edges in RUN -> state 00, counters 0000, and pipe_en 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_ctl.sv
// Pipeline run/halt/single-step controller with hazard stall and cycle counters.
// Define PIPE_CTL_HAZARD_EN to enable load-use / writeback-conflict stalls.
`timescale 1ns/1ps
module pipe_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        pause,
    input  logic        step,
    input  logic        clr,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [3:0]  ex_wa,
    input  logic        wb_regwrite,
    input  logic [3:0]  wb_wa,
    output logic        pipe_en,
    output logic        if_en,
    output logic        id_flush,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t cur;
    state_t nxt;
    logic   active;
    logic   stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= HALT;
        end else begin
            cur <= nxt;
        end
    end

    // A step strobe only arms STEP; the advance waits for a later tick.
    always_comb begin
        nxt = HALT;
        case (cur)
            HALT: begin
                if (!pause) begin
                    nxt = RUN;
                end else if (step) begin
                    nxt = STEP;
                end else begin
                    nxt = HALT;
                end
            end
            RUN: begin
                if (tick && pause) begin
                    nxt = HALT;
                end else begin
                    nxt = RUN;
                end
            end
            STEP: begin
                if (tick) begin
                    nxt = HALT;
                end else begin
                    nxt = STEP;
                end
            end
            default: nxt = HALT;
        endcase
    end

    assign active  = (cur == RUN) || (cur == STEP);
    assign pipe_en = rst && tick && active;
    assign state   = cur;

`ifdef PIPE_CTL_HAZARD_EN
    logic load_use;
    logic wb_conflict;

    assign load_use = ex_memread &&
        ((ex_wa == id_rs) || (id_uses_rt && (ex_wa == id_rt)));
    assign wb_conflict = wb_regwrite &&
        ((wb_wa == id_rs) || (id_uses_rt && (wb_wa == id_rt)));
    assign stall = load_use || wb_conflict;
`else
    logic unused_hazard;

    assign unused_hazard = ^{id_rs, id_rt, id_uses_rt, ex_memread,
                             ex_wa, wb_regwrite, wb_wa};
    assign stall = 1'b0;
`endif

    assign if_en    = pipe_en && !stall;
    assign id_flush = pipe_en && stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (clr) begin
            cycle_cnt <= '0;
        end else if (pipe_en) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

`ifdef PIPE_CTL_HAZARD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (id_flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl: stimulus queues expected tick responses,
// a negedge monitor pops and compares whenever a tick is presented.
`timescale 1ns/1ps
module tb_pipe_ctl;

`ifdef PIPE_CTL_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, tick, pause, step, clr;
    logic [3:0]  id_rs, id_rt, ex_wa, wb_wa;
    logic        id_uses_rt, ex_memread, wb_regwrite;
    logic        pipe_en, if_en, id_flush;
    logic [1:0]  state;
    logic [15:0] cycle_cnt, stall_cnt;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        pe;
        logic        ie;
        logic        fl;
        logic [15:0] cc;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    pipe_ctl dut (
        .clk(clk), .rst(rst), .tick(tick), .pause(pause), .step(step),
        .clr(clr), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_wa(ex_wa),
        .wb_regwrite(wb_regwrite), .wb_wa(wb_wa),
        .pipe_en(pipe_en), .if_en(if_en), .id_flush(id_flush),
        .state(state), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && tick) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick expected none at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, ".state"}, 32'(state), 32'(e.st));
                chk({e.name, ".pipe_en"}, 32'(pipe_en), 32'(e.pe));
                chk({e.name, ".if_en"}, 32'(if_en), 32'(e.ie));
                chk({e.name, ".id_flush"}, 32'(id_flush), 32'(e.fl));
                chk({e.name, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e.cc));
                chk({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input string nm, input logic [1:0] st,
                           input logic pe, input logic ie, input logic fl,
                           input logic [15:0] cc, input logic [15:0] sc);
        exp_t e;
        e.name = nm; e.st = st; e.pe = pe; e.ie = ie; e.fl = fl;
        e.cc = cc; e.sc = sc;
        q.push_back(e);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sat;
        sat = HZ ? 16'hFFFF : 16'h0000;
        rst = 1'b0; tick = 1'b0; pause = 1'b1; step = 1'b0; clr = 1'b0;
        id_rs = '0; id_rt = '0; ex_wa = '0; wb_wa = '0;
        id_uses_rt = 1'b0; ex_memread = 1'b0; wb_regwrite = 1'b0;

        #2 tick = 1'b1;
        #1;
        chk("rst.state", 32'(state), 0);
        chk("rst.cycle_cnt", 32'(cycle_cnt), 0);
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        chk("rst.pipe_en", 32'(pipe_en), 0);
        tick = 1'b0;

        cyc();
        rst = 1'b1;
        pause = 1'b0;
        cyc();
        chk("run_entry.state", 32'(state), 1);
        chk("run_idle.pipe_en", 32'(pipe_en), 0);
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++)
            do_tick("run", 2'b01, 1, 1, 0, 16'(k), 0);
        chk("run10.cycle_cnt", 32'(cycle_cnt), 10);

        pause = 1'b1;
        do_tick("pause_tick", 2'b01, 1, 1, 0, 16'd10, 0);
        chk("paused.state", 32'(state), 0);
        do_tick("halt_tick", 2'b00, 0, 0, 0, 16'd11, 0);
        step = 1'b1; cyc(); step = 1'b0;
        chk("step1.state", 32'(state), 2);
        step = 1'b1; cyc(); step = 1'b0;
        chk("step2.state", 32'(state), 2);
        do_tick("step_tick", 2'b10, 1, 1, 0, 16'd11, 0);
        chk("step_done.state", 32'(state), 0);
        chk("step_done.cycle_cnt", 32'(cycle_cnt), 12);

        step = 1'b1;
        do_tick("step_and_tick", 2'b00, 0, 0, 0, 16'd12, 0);
        step = 1'b0;
        chk("step_and_tick.state", 32'(state), 2);
        do_tick("late_step_tick", 2'b10, 1, 1, 0, 16'd12, 0);

        pause = 1'b0;
        cyc();
        chk("rerun.state", 32'(state), 1);
        ex_memread = 1'b1; ex_wa = 4'd5; id_rs = 4'd5;
        do_tick("load_use_rs", 2'b01, 1, !HZ, HZ, 16'd13, 0);
        id_rs = 4'd6; id_rt = 4'd5; id_uses_rt = 1'b0;
        do_tick("rt_unused", 2'b01, 1, 1, 0, 16'd14, 16'(HZ));
        ex_memread = 1'b0;
        wb_regwrite = 1'b1; wb_wa = 4'd3; id_rt = 4'd3;
        id_uses_rt = 1'b1; id_rs = 4'd9;
        do_tick("wb_rt", 2'b01, 1, !HZ, HZ, 16'd15, 16'(HZ));
        wb_wa = 4'd0; id_rs = 4'd0; id_rt = 4'd9;
        do_tick("wb_r0", 2'b01, 1, !HZ, HZ, 16'd16, 16'(2 * HZ));

        wb_regwrite = 1'b0; id_uses_rt = 1'b0; id_rt = 4'd0;
        ex_memread = 1'b1; ex_wa = 4'd7; id_rs = 4'd7;
        pause = 1'b1;
        do_tick("pause_stall", 2'b01, 1, !HZ, HZ, 16'd17, 16'(3 * HZ));
        step = 1'b1; cyc(); step = 1'b0;
        do_tick("step_stall", 2'b10, 1, !HZ, HZ, 16'd18, 16'(4 * HZ));
        chk("step_stall.state", 32'(state), 0);
        chk("step_stall.stall_cnt", 32'(stall_cnt), 32'(5 * HZ));

        pause = 1'b0; ex_wa = 4'd2; id_rs = 4'd2;
        cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr.cycle_cnt", 32'(cycle_cnt), 0);
        chk("clr.stall_cnt", 32'(stall_cnt), 0);
        mon_en = 1'b0;
        tick = 1'b1;
        repeat (65535) cyc();
        tick = 1'b0;
        mon_en = 1'b1;
        chk("bulk.cycle_cnt", 32'(cycle_cnt), 32'hFFFF);
        chk("bulk.stall_cnt", 32'(stall_cnt), 32'(sat));
        do_tick("sat", 2'b01, 1, !HZ, HZ, 16'hFFFF, sat);
        chk("wrap.cycle_cnt", 32'(cycle_cnt), 0);
        chk("sat.stall_cnt", 32'(stall_cnt), 32'(sat));
        clr = 1'b1;
        do_tick("clr_stall", 2'b01, 1, !HZ, HZ, 16'd0, sat);
        clr = 1'b0;
        chk("clr_stall.cycle_cnt", 32'(cycle_cnt), 0);
        chk("clr_stall.stall_cnt", 32'(stall_cnt), 0);

        ex_memread = 1'b0; id_rs = 4'd0; ex_wa = 4'd0;
        do_tick("pre_rst", 2'b01, 1, 1, 0, 16'd0, 0);
        mon_en = 1'b0;
        tick = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst.state", 32'(state), 0);
        chk("arst.cycle_cnt", 32'(cycle_cnt), 0);
        chk("arst.pipe_en", 32'(pipe_en), 0);
        chk("arst.if_en", 32'(if_en), 0);
        chk("arst.id_flush", 32'(id_flush), 0);
        tick = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst.state", 32'(state), 1);

        chk("queue_drain", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
